mulaw_dec_arb: RTL

Round-robin scheduler that shares one `mulaw_dec` instance between `P_NUM_CH` encoded-sample requesters. Each channel has its own valid/ready holding register. At most one sample per cycle is issued to the decoder, which has no backpressure. A channel-ID tag travels down a shift pipe that matches the decoder's fixed latency, so every decoded word is returned with its channel ID. The block sits between the per-channel µ-law sources and the decoder, and drives the decoded stream onward.

---
 rtl/mulaw_dec_arb.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mulaw_dec_arb.sv
// Round-robin scheduler sharing one fixed-latency mu-law decoder between P_NUM_CH channels.
// A channel-ID tag pipe matched to the decoder latency labels every decoded word.
module mulaw_dec_arb #(
    parameter int unsigned P_NUM_CH  = 4,
    parameter int unsigned P_ENC_DW  = 8,
    parameter int unsigned P_DEC_DW  = 14,
    parameter int unsigned P_DEC_LAT = 6,
    localparam int unsigned P_CH_W   = $clog2(P_NUM_CH)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [P_NUM_CH*P_ENC_DW-1:0] i_ch_dt,
    input  logic [P_NUM_CH-1:0]          i_ch_valid,
    output logic [P_NUM_CH-1:0]          o_ch_ready,
    input  logic [P_NUM_CH-1:0]          i_ch_mask,
    output logic [P_ENC_DW-1:0]          o_dec_dt,
    output logic                         o_dec_enable,
    input  logic [P_DEC_DW-1:0]          i_dec_dt,
    input  logic                         i_dec_enable,
    output logic [P_DEC_DW-1:0]          o_dt,
    output logic                         o_valid,
    output logic [P_CH_W-1:0]            o_ch_id,
    output logic                         o_busy,
    output logic                         o_err
);

    localparam int unsigned FlushW = $clog2(P_DEC_LAT + 2);
    localparam logic [FlushW-1:0] FlushInit = FlushW'(P_DEC_LAT + 1);
    localparam logic [P_CH_W-1:0] PtrInit   = P_CH_W'(P_NUM_CH - 1);

    logic [FlushW-1:0]   flush_q, flush_d;
    logic                flush_done;
    logic [P_NUM_CH-1:0] hold_valid_q, hold_valid_d;
    logic [P_ENC_DW-1:0] hold_dt_q [P_NUM_CH];
    logic [P_ENC_DW-1:0] hold_dt_d [P_NUM_CH];
    logic [P_CH_W-1:0]   ptr_q, ptr_d;
    logic                dec_en_q, dec_en_d;
    logic [P_ENC_DW-1:0] dec_dt_q, dec_dt_d;
    logic [P_DEC_LAT:0]  tag_v_q, tag_v_d;
    logic [P_CH_W-1:0]   tag_id_q [P_DEC_LAT+1];
    logic [P_CH_W-1:0]   tag_id_d [P_DEC_LAT+1];
    logic                valid_q, valid_d;
    logic [P_DEC_DW-1:0] dt_q, dt_d;
    logic [P_CH_W-1:0]   ch_id_q, ch_id_d;
    logic                err_q, err_d;

    logic [P_NUM_CH-1:0] eligible, grant, load;
    logic                grant_any;
    logic [P_CH_W-1:0]   grant_id;
    logic [P_CH_W-1:0]   idx;

    assign flush_done = (flush_q == '0);
    assign eligible   = hold_valid_q & i_ch_mask & {P_NUM_CH{flush_done}};
    assign o_ch_ready = {P_NUM_CH{flush_done}} & (~hold_valid_q | grant);
    assign load       = i_ch_valid & o_ch_ready;

    // Scan upward from the channel after the last winner.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int unsigned i = 1; i <= P_NUM_CH; i++) begin
            idx = P_CH_W'((32'(ptr_q) + i) % P_NUM_CH);
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

    always_comb begin
        flush_d      = flush_done ? '0 : flush_q - 1'b1;
        hold_valid_d = (hold_valid_q & ~grant) | load;
        for (int c = 0; c < int'(P_NUM_CH); c++) begin
            hold_dt_d[c] = load[c] ? i_ch_dt[c*P_ENC_DW +: P_ENC_DW] : hold_dt_q[c];
        end
        ptr_d    = grant_any ? grant_id : ptr_q;
        dec_en_d = grant_any;
        dec_dt_d = grant_any ? hold_dt_q[grant_id] : dec_dt_q;

        tag_v_d     = {tag_v_q[P_DEC_LAT-1:0], grant_any};
        tag_id_d[0] = grant_id;
        for (int k = 1; k <= int'(P_DEC_LAT); k++) begin
            tag_id_d[k] = tag_id_q[k-1];
        end

        // Decoder output is ignored while stale pre-reset results drain.
        valid_d = flush_done & i_dec_enable;
        dt_d    = valid_d ? i_dec_dt : dt_q;
        ch_id_d = valid_d ? tag_id_q[P_DEC_LAT] : ch_id_q;
        err_d   = err_q | (flush_done & (i_dec_enable != tag_v_q[P_DEC_LAT]));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            flush_q      <= FlushInit;
            hold_valid_q <= '0;
            hold_dt_q    <= '{default: '0};
            ptr_q        <= PtrInit;
            dec_en_q     <= 1'b0;
            dec_dt_q     <= '0;
            tag_v_q      <= '0;
            tag_id_q     <= '{default: '0};
            valid_q      <= 1'b0;
            dt_q         <= '0;
            ch_id_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            flush_q      <= flush_d;
            hold_valid_q <= hold_valid_d;
            hold_dt_q    <= hold_dt_d;
            ptr_q        <= ptr_d;
            dec_en_q     <= dec_en_d;
            dec_dt_q     <= dec_dt_d;
            tag_v_q      <= tag_v_d;
            tag_id_q     <= tag_id_d;
            valid_q      <= valid_d;
            dt_q         <= dt_d;
            ch_id_q      <= ch_id_d;
            err_q        <= err_d;
        end
    end

    assign o_dec_enable = dec_en_q;
    assign o_dec_dt     = dec_dt_q;
    assign o_valid      = valid_q;
    assign o_dt         = dt_q;
    assign o_ch_id      = ch_id_q;
    assign o_err        = err_q;
    assign o_busy       = ~flush_done | (|hold_valid_q) | (|tag_v_q) | dec_en_q;

endmodule
